// File: rtl/score_font_pkg.sv
// Shared constants for the score overlay: 3x5 digit font, cell geometry, BCD converter states.
// Font rows are packed row-major with bit 14 as the top-left pixel.
package score_font_pkg;

  localparam int GLYPH_W    = 3;
  localparam int GLYPH_H    = 5;
  localparam int CELL_W     = 4;
  localparam int NUM_DIGITS = 3;

  localparam logic [14:0] GLYPHS [10] = '{
    15'b111_101_101_101_111,  // 0
    15'b010_110_010_010_111,  // 1
    15'b111_001_111_100_111,  // 2
    15'b111_001_111_001_111,  // 3
    15'b101_101_111_001_001,  // 4
    15'b111_100_111_001_111,  // 5
    15'b111_100_111_101_111,  // 6
    15'b111_001_001_001_001,  // 7
    15'b111_101_111_101_111,  // 8
    15'b111_101_111_001_111   // 9
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } conv_state_t;

  // Non-decimal nibbles and out-of-glyph coordinates read as blank.
  function automatic logic glyph_bit(input logic [3:0] d, input logic [2:0] row,
                                     input logic [1:0] col);
    logic [14:0] g;
    logic [3:0]  idx;
    if (d > 4'd9 || int'(row) >= GLYPH_H || int'(col) >= GLYPH_W) return 1'b0;
    g   = GLYPHS[d];
    idx = 4'(GLYPH_W * GLYPH_H - 1 - GLYPH_W * int'(row) - int'(col));
    return g[idx];
  endfunction

endpackage

// File: rtl/score_bin2bcd.sv
// Double-dabble binary-to-BCD converter for the 8-bit score, one shift per cycle.
// start in cycle N -> bcd updated and done pulsed in cycle N+9; start outside IDLE is ignored.
module score_bin2bcd
  import score_font_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        done,
  output logic [11:0] bcd
);

  conv_state_t state, state_n;
  logic [19:0] sh, sh_n, adj;
  logic [2:0]  cnt, cnt_n;
  logic [11:0] bcd_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sh    <= '0;
      cnt   <= '0;
      bcd   <= '0;
    end else begin
      state <= state_n;
      sh    <= sh_n;
      cnt   <= cnt_n;
      bcd   <= bcd_n;
    end
  end

  always_comb begin
    state_n = state;
    sh_n    = sh;
    cnt_n   = cnt;
    bcd_n   = bcd;
    done    = 1'b0;
    adj     = sh;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sh[8 + 4*i +: 4] >= 4'd5) adj[8 + 4*i +: 4] = sh[8 + 4*i +: 4] + 4'd3;
    end
    case (state)
      IDLE: begin
        if (start) begin
          sh_n    = {12'h000, bin};
          cnt_n   = '0;
          state_n = CONV;
        end
      end
      CONV: begin
        sh_n  = {adj[18:0], 1'b0};
        cnt_n = cnt + 3'd1;
        if (cnt == 3'd7) begin
          // Latch on the final shift so the new digits are visible during the COMMIT cycle.
          bcd_n   = sh_n[19:8];
          state_n = COMMIT;
        end
      end
      COMMIT: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: rtl/score_overlay.sv
// Three-digit score overlay: converts the score once per frame and renders it in a 3x5 font.
// Build option: LEADING_ZERO_BLANK_EN blanks leading zero glyphs (digits output unchanged).
module score_overlay
  import score_font_pkg::*;
#(
  parameter int X0         = 8,
  parameter int Y0         = 8,
  parameter int SCALE_LOG2 = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  score,
  input  logic        frame_start,
  input  logic [9:0]  hpos,
  input  logic [9:0]  vpos,
  output logic        pixel_on,
  output logic        conv_done,
  output logic [11:0] digits
);

  localparam logic [10:0] X0_L    = 11'(X0);
  localparam logic [10:0] Y0_L    = 11'(Y0);
  localparam logic [10:0] FIELD_W = 11'((NUM_DIGITS * CELL_W) << SCALE_LOG2);
  localparam logic [10:0] FIELD_H = 11'(GLYPH_H << SCALE_LOG2);

  score_bin2bcd u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (frame_start),
    .bin   (score),
    .done  (conv_done),
    .bcd   (digits)
  );

  logic        in_field;
  logic [3:0]  col;
  logic [2:0]  row;
  logic [3:0]  nib;
  logic        blank;
  logic        pix_next;

  // 11-bit compares keep hpos < X0 from wrapping into the field.
  assign in_field = ({1'b0, hpos} >= X0_L) && ({1'b0, hpos} < X0_L + FIELD_W) &&
                    ({1'b0, vpos} >= Y0_L) && ({1'b0, vpos} < Y0_L + FIELD_H);
  assign col = 4'(({1'b0, hpos} - X0_L) >> SCALE_LOG2);
  assign row = 3'(({1'b0, vpos} - Y0_L) >> SCALE_LOG2);

  always_comb begin
    nib   = digits[3:0];
    blank = 1'b0;
    case (col[3:2])
      2'd0:    nib = digits[11:8];
      2'd1:    nib = digits[7:4];
      default: nib = digits[3:0];
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    if (col[3:2] == 2'd0) blank = (digits[11:8] == 4'd0);
    if (col[3:2] == 2'd1) blank = (digits[11:8] == 4'd0) && (digits[7:4] == 4'd0);
`endif
    pix_next = in_field && (col[1:0] != 2'd3) && !blank && glyph_bit(nib, row, col[1:0]);
  end

  always_ff @(posedge clk) begin
    if (reset) pixel_on <= 1'b0;
    else       pixel_on <= pix_next;
  end

endmodule

// File: tb/tb_score_overlay.sv
// Directed + random bench for score_overlay against a decimal/font reference model.
module tb_score_overlay;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  score;
  logic        frame_start;
  logic [9:0]  hpos, vpos;
  logic        pixel_on, conv_done;
  logic [11:0] digits;

  int errors = 0;
  int checks = 0;
  int committed = 0;

  // Reference font, one 3-bit row per entry, bit 2 = leftmost pixel.
  logic [2:0] font [10][5] = '{
    '{3'b111, 3'b101, 3'b101, 3'b101, 3'b111},
    '{3'b010, 3'b110, 3'b010, 3'b010, 3'b111},
    '{3'b111, 3'b001, 3'b111, 3'b100, 3'b111},
    '{3'b111, 3'b001, 3'b111, 3'b001, 3'b111},
    '{3'b101, 3'b101, 3'b111, 3'b001, 3'b001},
    '{3'b111, 3'b100, 3'b111, 3'b001, 3'b111},
    '{3'b111, 3'b100, 3'b111, 3'b101, 3'b111},
    '{3'b111, 3'b001, 3'b001, 3'b001, 3'b001},
    '{3'b111, 3'b101, 3'b111, 3'b101, 3'b111},
    '{3'b111, 3'b101, 3'b111, 3'b001, 3'b111}
  };

  score_overlay dut (
    .clk         (clk),
    .reset       (reset),
    .score       (score),
    .frame_start (frame_start),
    .hpos        (hpos),
    .vpos        (vpos),
    .pixel_on    (pixel_on),
    .conv_done   (conv_done),
    .digits      (digits)
  );

  always #20 clk = ~clk;

  function automatic logic [11:0] model_bcd(input int sc);
    return 12'((sc / 100) * 256 + ((sc / 10) % 10) * 16 + sc % 10);
  endfunction

  function automatic logic model_pix(input int h, input int v, input int sc);
    int s, c, r, d, gc, val;
    logic [2:0] bits;
    s = 2;
    if (h < 8 || h >= 8 + 12 * s || v < 8 || v >= 8 + 5 * s) return 1'b0;
    c  = (h - 8) / s;
    r  = (v - 8) / s;
    d  = c / 4;
    gc = c % 4;
    if (gc == 3) return 1'b0;
    val = (d == 0) ? sc / 100 : (d == 1) ? (sc / 10) % 10 : sc % 10;
`ifdef LEADING_ZERO_BLANK_EN
    if (d == 0 && sc < 100) return 1'b0;
    if (d == 1 && sc < 10) return 1'b0;
`endif
    bits = font[val][r];
    return bits[2 - gc];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // frame_start in cycle N; optional re-pulse and score change at N+k (0 = none).
  task automatic convert(input logic [7:0] sc, input int repulse_at, input int change_at,
                         input logic [7:0] sc2);
    int pulses;
    pulses = 0;
    score = sc;
    frame_start = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      frame_start = (k == repulse_at);
      if (k == change_at) score = sc2;
      if (conv_done === 1'b1) pulses++;
      chk($sformatf("conv_done_n%0d_s%0d", k, sc), 32'(conv_done), 32'(k == 9));
      if (k == 9) chk($sformatf("digits_s%0d", sc), 32'(digits), 32'(model_bcd(int'(sc))));
    end
    frame_start = 1'b0;
    chk($sformatf("pulse_count_s%0d", sc), pulses, 1);
    committed = int'(sc);
  endtask

  task automatic scan(input int h_lo, input int h_hi, input int v_lo, input int v_hi);
    for (int v = v_lo; v <= v_hi; v++) begin
      for (int h = h_lo; h <= h_hi; h++) begin
        hpos = 10'(h);
        vpos = 10'(v);
        tick();
        chk($sformatf("pixel_h%0d_v%0d_s%0d", h, v, committed), 32'(pixel_on),
            32'(model_pix(h, v, committed)));
      end
    end
  endtask

  initial begin
    int rs, rh, rv;
    reset = 1'b1;
    frame_start = 1'b0;
    score = 8'd0;
    hpos = 10'd0;
    vpos = 10'd0;
    repeat (3) tick();
    chk("reset_digits", 32'(digits), 32'h000);
    chk("reset_pixel_on", 32'(pixel_on), 0);
    chk("reset_conv_done", 32'(conv_done), 0);
    reset = 1'b0;
    tick();

    convert(8'd0, 0, 0, 8'd0);
    convert(8'd255, 0, 0, 8'd0);
    convert(8'd100, 0, 0, 8'd0);
    convert(8'd9, 0, 0, 8'd0);
    // re-pulse ignored mid-conversion; late score change does not leak in
    convert(8'd137, 4, 2, 8'd42);
    chk("score_after_change", 32'(digits), 32'h137);

    // ones cell of "180": top row of "0"
    convert(8'd180, 0, 0, 8'd0);
    for (int h = 24; h <= 29; h++) begin
      hpos = 10'(h);
      vpos = 10'd8;
      tick();
      chk($sformatf("zero_top_h%0d", h), 32'(pixel_on), 1);
    end
    scan(0, 35, 6, 19);

    // reset mid-conversion aborts
    score = 8'd200;
    frame_start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      frame_start = 1'b0;
      if (k == 5) reset = 1'b1;
    end
    tick();
    reset = 1'b0;
    chk("abort_digits", 32'(digits), 32'h000);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("abort_no_done_%0d", k), 32'(conv_done), 0);
      tick();
    end
    committed = 0;
    convert(8'd61, 0, 0, 8'd0);

    // leading-zero behaviour depends on build option; model follows the same macro
    convert(8'd7, 0, 0, 8'd0);
    scan(7, 32, 7, 18);
    convert(8'd45, 0, 0, 8'd0);
    scan(7, 32, 7, 18);

    for (int i = 0; i < 16; i++) begin
      rs = int'($urandom_range(255, 0));
      convert(8'(rs), 0, 0, 8'd0);
      for (int j = 0; j < 24; j++) begin
        if (j % 2 == 0) begin
          rh = int'($urandom_range(799, 0));
          rv = int'($urandom_range(524, 0));
        end else begin
          rh = int'($urandom_range(34, 0));
          rv = int'($urandom_range(20, 4));
        end
        hpos = 10'(rh);
        vpos = 10'(rv);
        tick();
        chk($sformatf("rand_pix_h%0d_v%0d_s%0d", rh, rv, rs), 32'(pixel_on),
            32'(model_pix(rh, rv, rs)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
